// File: rtl/contrast.sv
// contrast: per-pixel contrast/brightness stage for one 8-bit colour channel.
//
// Computes  out = sat( shift_a( in +/- shift_b(in) ) )  with saturation to
// 0..255, registered with one cycle of latency and one pixel per clock.
// When en_cp is low the input pixel is passed through unchanged, still with
// one cycle of latency.
//
// Ports:
//   clk        rising-edge clock
//   resetN     asynchronous, active-low reset (clears color_out)
//   en_cp      1 = apply processing, 0 = bypass
//   cp_param   {sign, shifter_b{dir,val}, shifter_a{dir,val}}, sampled every cycle
//   color_in   unsigned input pixel
//   color_out  unsigned processed pixel (registered)
//
// Interface timing: there is no valid/ready handshake. A pixel is accepted on
// every rising edge, and color_out always reflects the color_in, en_cp and
// cp_param sampled on the previous rising edge.

package pkg;

    typedef enum logic [1:0] {
        DIR_ZERO  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
        // Encoding 3 is not named and behaves as DIR_ZERO.
    } shift_dir_e;

    typedef enum logic {
        SIGN_ADD = 1'b0,
        SIGN_SUB = 1'b1
    } sign_e;

    typedef struct packed {
        shift_dir_e  dir;
        logic [2:0]  val;
    } shifter_t;

    typedef struct packed {
        sign_e    sign;
        shifter_t shifter_b;
        shifter_t shifter_a;
    } cp_param_t;

endpackage

module contrast (
    input  logic           clk,
    input  logic           resetN,
    input  logic           en_cp,
    input  pkg::cp_param_t cp_param,
    input  logic [7:0]     color_in,
    output logic [7:0]     color_out
);

    import pkg::*;

    // 26 bits holds the worst case: 255 + (255 << 7) = 32895, then << 7
    // gives about 4.2M, well inside the signed 26-bit range.
    localparam int DW = 26;

    logic signed [DW-1:0] x;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] z;
    logic        [7:0]    sat;

    always_comb begin
        x   = {{(DW-8){1'b0}}, color_in};
        b   = '0;
        y   = '0;
        z   = '0;
        sat = 8'h00;

        // A ZERO direction removes the b term entirely; it is not a shift by 0.
        case (cp_param.shifter_b.dir)
            DIR_LEFT:  b = x << cp_param.shifter_b.val;
            DIR_RIGHT: b = x >> cp_param.shifter_b.val;
            default:   b = '0;
        endcase

        if (cp_param.sign == SIGN_SUB) begin
            y = x - b;
        end else begin
            y = x + b;
        end

        // y can be negative here, so the right shift must be arithmetic
        // (floors toward minus infinity).
        case (cp_param.shifter_a.dir)
            DIR_LEFT:  z = y <<< cp_param.shifter_a.val;
            DIR_RIGHT: z = y >>> cp_param.shifter_a.val;
            default:   z = y;
        endcase

        if (z < 0) begin
            sat = 8'h00;
        end else if (z > 26'sd255) begin
            sat = 8'hFF;
        end else begin
            sat = z[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            color_out <= 8'h00;
        end else if (en_cp) begin
            color_out <= sat;
        end else begin
            color_out <= color_in;
        end
    end

endmodule

// File: tb/tb_contrast.sv
// tb_contrast: self-checking bench for the contrast stage.
//
// Directed steps cover reset, bypass, the add/subtract paths, both
// saturation limits and mid-stream enable changes; a randomized section
// then compares the DUT against an arithmetic reference model.

module tb_contrast;

    import pkg::*;

    localparam logic [1:0] Z = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] R = 2'd2;
    localparam logic [1:0] X3 = 2'd3;

    logic       clk;
    logic       resetN;
    logic       en_cp;
    cp_param_t  cp_param;
    logic [7:0] color_in;
    logic [7:0] color_out;

    int n_cmp;
    int n_err;
    logic [7:0] exp_q[$];

    contrast dut (
        .clk       (clk),
        .resetN    (resetN),
        .en_cp     (en_cp),
        .cp_param  (cp_param),
        .color_in  (color_in),
        .color_out (color_out)
    );

    // Clock / reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic cp_param_t mk(input logic sub, input logic [1:0] bd, input logic [2:0] bv,
                                     input logic [1:0] ad, input logic [2:0] av);
        cp_param_t p;
        p.sign          = sign_e'(sub);
        p.shifter_b.dir = shift_dir_e'(bd);
        p.shifter_b.val = bv;
        p.shifter_a.dir = shift_dir_e'(ad);
        p.shifter_a.val = av;
        return p;
    endfunction

    // Reference model: plain integer arithmetic, shifts as multiply/divide
    // by powers of two, floor division done explicitly.
    function automatic logic [7:0] ref_model(input logic en, input cp_param_t p, input logic [7:0] c);
        int x, b, y, z, sb, sa;
        if (!en) return c;
        x  = int'(c);
        sb = 1 << p.shifter_b.val;
        sa = 1 << p.shifter_a.val;
        if (p.shifter_b.dir == DIR_LEFT)       b = x * sb;
        else if (p.shifter_b.dir == DIR_RIGHT) b = x / sb;
        else                                   b = 0;
        y = (p.sign == SIGN_SUB) ? (x - b) : (x + b);
        if (p.shifter_a.dir == DIR_LEFT) begin
            z = y * sa;
        end else if (p.shifter_a.dir == DIR_RIGHT) begin
            z = y / sa;
            if ((y % sa != 0) && (y < 0)) z = z - 1;
        end else begin
            z = y;
        end
        if (z < 0)   return 8'h00;
        if (z > 255) return 8'hFF;
        return 8'(z);
    endfunction

    // Scoreboard check: pops the oldest expectation and compares.
    task automatic check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %02h required <empty expected queue>", tag, color_out);
            return;
        end
        e = exp_q.pop_front();
        n_cmp++;
        assert (color_out === e) else begin
            n_err++;
            $error("FAIL %s: observed %02h required %02h", tag, color_out, e);
        end
    endtask

    // Driver: apply one pixel on the falling edge, check after the next rising edge.
    task automatic step(input logic en, input cp_param_t p, input logic [7:0] c,
                        input logic [7:0] e, input string tag);
        @(negedge clk);
        en_cp    = en;
        cp_param = p;
        color_in = c;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        resetN   = 1'b0;
        en_cp    = 1'b1;
        cp_param = mk(1'b0, Z, 3'd0, Z, 3'd0);
        color_in = 8'hAB;

        // Reset held: output stays zero across edges.
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(8'h00);
        check("reset_hold");

        // Release with identity processing: input appears one edge later.
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(8'hAB);
        check("reset_release_en");

        // Asynchronous assertion clears the output without a clock edge.
        @(negedge clk);
        resetN = 1'b0;
        #1;
        exp_q.push_back(8'h00);
        check("async_reset");

        // Release in bypass mode.
        @(negedge clk);
        resetN   = 1'b1;
        en_cp    = 1'b0;
        color_in = 8'hAB;
        @(posedge clk);
        #1;
        exp_q.push_back(8'hAB);
        check("reset_release_bypass");

        // Bypass stream, back-to-back; cp_param is ignored.
        step(1'b0, mk(1'b1, L, 3'd7, L, 3'd7), 8'h00, 8'h00, "bypass_00");
        step(1'b0, mk(1'b1, L, 3'd7, L, 3'd7), 8'h5A, 8'h5A, "bypass_5a");
        step(1'b0, mk(1'b1, L, 3'd7, L, 3'd7), 8'hFF, 8'hFF, "bypass_ff");

        // Add path.
        step(1'b1, mk(1'b0, R, 3'd1, Z, 3'd0), 8'd100, 8'd150, "add_r1");
        // Upper saturation: (200-50)<<1 = 300.
        step(1'b1, mk(1'b1, R, 3'd2, L, 3'd1), 8'd200, 8'd255, "sat_high");
        // Lower saturation: -10 and -5.
        step(1'b1, mk(1'b1, L, 3'd1, Z, 3'd0), 8'd10, 8'd0, "sat_low");
        step(1'b1, mk(1'b1, L, 3'd1, R, 3'd1), 8'd10, 8'd0, "sat_low_asr");

        // Scaling stream, then bypass switched on mid-stream.
        step(1'b1, mk(1'b0, Z, 3'd5, R, 3'd1), 8'hFF, 8'h7F, "scale_ff");
        step(1'b1, mk(1'b0, Z, 3'd5, R, 3'd1), 8'h80, 8'h40, "scale_80");
        step(1'b1, mk(1'b0, Z, 3'd5, R, 3'd1), 8'h01, 8'h00, "scale_01");
        step(1'b0, mk(1'b0, Z, 3'd5, R, 3'd1), 8'h81, 8'h81, "switch_bypass");
        step(1'b1, mk(1'b0, Z, 3'd5, R, 3'd1), 8'h81, 8'h40, "switch_back");

        // Boundary settings.
        step(1'b1, mk(1'b1, L, 3'd0, Z, 3'd0), 8'd77, 8'd0, "sub_equal");
        step(1'b1, mk(1'b0, L, 3'd0, L, 3'd0), 8'd60, 8'd120, "shift_by_0");
        step(1'b1, mk(1'b0, L, 3'd7, L, 3'd7), 8'd255, 8'd255, "worst_case");
        step(1'b1, mk(1'b1, L, 3'd7, L, 3'd7), 8'd255, 8'd0, "worst_case_sub");
        step(1'b1, mk(1'b0, X3, 3'd4, X3, 3'd3), 8'd90, 8'd90, "dir3_as_zero");
        step(1'b1, mk(1'b0, R, 3'd7, R, 3'd0), 8'd200, 8'd201, "right7");
        step(1'b1, mk(1'b1, R, 3'd2, R, 3'd1), 8'd99, 8'd37, "sub_asr_pos");

        // Randomized stream against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic      en;
            cp_param_t p;
            logic [7:0] c;
            en = ($urandom_range(0, 7) != 0);
            p  = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            c  = 8'($urandom_range(0, 255));
            step(en, p, c, ref_model(en, p, c), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/contrast.md
Name: contrast

Overview:
- Per-pixel contrast/brightness stage for one 8-bit colour channel in the video enhancement pipeline.
- Takes one pixel per clock and scales it with two programmable shifters and an add/subtract.
  - out = shift_a(in ± shift_b(in)), saturated to 0..255.
- Registered, 1-cycle latency, fully pipelined. Bypasses the input unchanged when disabled.

Parameters:
- None. Field widths come from pkg::cp_param_t.
  - sign: 1 bit, ADD=0, SUB=1.
  - shifter_x.dir: 2 bits, ZERO=0, LEFT=1, RIGHT=2; value 3 is treated as ZERO.
  - shifter_x.val: 3 bits unsigned, shift amount 0..7.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- en_cp  in  1  1 = apply contrast processing; 0 = bypass.
- cp_param  in  cp_param_t  {sign, shifter_b{dir,val}, shifter_a{dir,val}}; quasi-static, sampled every cycle.
- color_in  in  8  unsigned input pixel, one per clock.
- color_out  out  8  unsigned processed pixel, registered.

Behaviour:
- Reset and interface:
  - One clock domain (clk). Reset is asynchronous and active-low (resetN).
  - resetN low: color_out = 8'h00 immediately. Any in-flight pixel is discarded.
  - First valid output is 1 cycle after the first edge with resetN high.
  - No handshake. A new color_in is accepted on every rising edge.
  - color_out reflects the color_in, en_cp and cp_param sampled on the previous rising edge.
- Datapath (combinational, then one output register). Internal arithmetic is signed, minimum 26 bits.
  - x = zero-extended color_in.
  - b term from shifter_b:
    - LEFT: b = x << val_b.
    - RIGHT: b = x >> val_b (logical).
    - ZERO: b = 0, i.e. the term is disabled, not "shift by 0".
  - y = x + b when sign=ADD; y = x - b when sign=SUB. y may be negative.
  - z from shifter_a:
    - LEFT: z = y << val_a.
    - RIGHT: z = y >>> val_a (arithmetic; floors toward minus infinity).
    - ZERO: z = y (pass-through).
  - Saturation: z < 0 gives 0; z > 255 gives 255; otherwise z[7:0]. No wrap-around under any setting.
- en_cp = 0: color_out <= color_in, still with 1-cycle latency. cp_param is ignored.
- cp_param or en_cp changing mid-stream takes effect on the pixel sampled at the same edge. There is no glitch handling or extra latency.
- Boundary settings:
  - val = 0 with LEFT or RIGHT is an identity shift (b = x, or z = y).
  - SUB with b = x gives 0.
  - Worst case: x=255, LEFT 7 on both shifters, stays within 26 bits without overflow.

Test Plan:
- Reset: hold resetN=0 while driving color_in=0xAB -> color_out=0x00. Release resetN -> on the next edge color_out=0xAB, whether en_cp=1 with b=ZERO/a=ZERO or en_cp=0.
- Bypass: en_cp=0, stream 0x00,0x5A,0xFF -> color_out gives 0x00,0x5A,0xFF, each one cycle later, back-to-back.
- ADD path: en_cp=1, ADD, b=RIGHT 1, a=ZERO, color_in=100 -> 150.
- Upper saturation: en_cp=1, SUB, b=RIGHT 2, a=LEFT 1, color_in=200 -> (200-50)<<1 = 300 -> 255.
- Lower saturation and negative handling:
  - SUB, b=LEFT 1, a=ZERO, color_in=10 -> -10 -> 0.
  - SUB, b=LEFT 1, a=RIGHT 1, color_in=10 -> -5 -> 0.
- Scaling and streaming: ADD, b=ZERO, a=RIGHT 1, stream 0xFF,0x80,0x01 -> 0x7F,0x40,0x00. Then switch en_cp to 0 mid-stream -> the pixel sampled at that edge is output unmodified.
